// File: rtl/axi4s_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_router_pkg
// Purpose  : Shared types and constants for the AXI4-Stream one-to-many router.
// Revision : 1.0 - initial release
// ============================================================================
package axi4s_router_pkg;

    // Router packet-tracking states
    typedef enum logic [1:0] {
        IDLE_E  = 2'd0,   // waiting for the first beat of a packet
        ROUTE_E = 2'd1,   // forwarding a packet to its locked output
        DROP_E  = 2'd2    // sinking a packet with an invalid destination
    } router_state_t;

    localparam int DROP_CNT_WIDTH_C = 32;

endpackage : axi4s_router_pkg
`default_nettype wire

// File: rtl/axi4s_router_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_router_out_reg
// Purpose  : Single registered output stage shared by all router outputs.
//            Holds valid, selected output index and the packed payload.
//            A load while the register pops is a reload (full throughput).
// Revision : 1.0 - initial release
// ============================================================================
module axi4s_router_out_reg #(
    parameter int NR_OF_SLAVES_P  = 4,
    parameter int SEL_WIDTH_P     = 2,
    parameter int PAYLOAD_WIDTH_P = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load,
    input  logic [SEL_WIDTH_P-1:0]     i_sel,
    input  logic [PAYLOAD_WIDTH_P-1:0] i_payload,
    input  logic [NR_OF_SLAVES_P-1:0]  i_ready,
    output logic                       o_vld,
    output logic [PAYLOAD_WIDTH_P-1:0] o_payload,
    output logic [NR_OF_SLAVES_P-1:0]  o_tvalid,
    output logic                       o_pop
);

    logic                       r_vld;
    logic [SEL_WIDTH_P-1:0]     r_sel;
    logic [PAYLOAD_WIDTH_P-1:0] r_payload;

    // Decode the selected output; only one valid bit can ever be high
    for (genvar i = 0; i < NR_OF_SLAVES_P; i++) begin : g_vld
        assign o_tvalid[i] = r_vld && (r_sel == SEL_WIDTH_P'(i));
    end

    assign o_pop     = |(o_tvalid & i_ready);
    assign o_vld     = r_vld;
    assign o_payload = r_payload;

    // Load on accept, clear on pop; payload otherwise held stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= 1'b0;
            r_sel     <= '0;
            r_payload <= '0;
        end else if (i_load) begin
            r_vld     <= 1'b1;
            r_sel     <= i_sel;
            r_payload <= i_payload;
        end else if (o_pop) begin
            r_vld     <= 1'b0;
        end
    end

endmodule : axi4s_router_out_reg
`default_nettype wire

// File: rtl/axi4s_s2m_router.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_s2m_router
// Purpose  : One-to-many AXI4-Stream packet router. The first beat's tdest
//            selects the output, which stays locked until tlast. Packets with
//            an out-of-range tdest are sunk.
// Options  : AXI4S_ROUTER_DROP_CNT_EN - adds o_drop_cnt, a saturating count
//            of dropped packets.
// Revision : 1.0 - initial release
// ============================================================================
module axi4s_s2m_router
    import axi4s_router_pkg::*;
#(
    parameter int NR_OF_SLAVES_P   = 4,
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_STRB_WIDTH_P = 4,
    parameter int AXI_KEEP_WIDTH_P = 4,
    parameter int AXI_ID_WIDTH_P   = 2,
    parameter int AXI_DEST_WIDTH_P = 2,
    parameter int AXI_USER_WIDTH_P = 1
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               i_mst_tvalid,
    output logic                                               o_mst_tready,
    input  logic [AXI_DATA_WIDTH_P-1:0]                        i_mst_tdata,
    input  logic [AXI_STRB_WIDTH_P-1:0]                        i_mst_tstrb,
    input  logic [AXI_KEEP_WIDTH_P-1:0]                        i_mst_tkeep,
    input  logic                                               i_mst_tlast,
    input  logic [AXI_ID_WIDTH_P-1:0]                          i_mst_tid,
    input  logic [AXI_DEST_WIDTH_P-1:0]                        i_mst_tdest,
    input  logic [AXI_USER_WIDTH_P-1:0]                        i_mst_tuser,
    output logic [NR_OF_SLAVES_P-1:0]                          o_slv_tvalid,
    input  logic [NR_OF_SLAVES_P-1:0]                          i_slv_tready,
    output logic [NR_OF_SLAVES_P-1:0][AXI_DATA_WIDTH_P-1:0]    o_slv_tdata,
    output logic [NR_OF_SLAVES_P-1:0][AXI_STRB_WIDTH_P-1:0]    o_slv_tstrb,
    output logic [NR_OF_SLAVES_P-1:0][AXI_KEEP_WIDTH_P-1:0]    o_slv_tkeep,
    output logic [NR_OF_SLAVES_P-1:0]                          o_slv_tlast,
    output logic [NR_OF_SLAVES_P-1:0][AXI_ID_WIDTH_P-1:0]      o_slv_tid,
    output logic [NR_OF_SLAVES_P-1:0][AXI_DEST_WIDTH_P-1:0]    o_slv_tdest,
    output logic [NR_OF_SLAVES_P-1:0][AXI_USER_WIDTH_P-1:0]    o_slv_tuser
`ifdef AXI4S_ROUTER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_WIDTH_C-1:0]                        o_drop_cnt
`endif
);

    localparam int SEL_W_C = $clog2(NR_OF_SLAVES_P);
    localparam int PAY_W_C = AXI_DATA_WIDTH_P + AXI_STRB_WIDTH_P + AXI_KEEP_WIDTH_P + 1
                           + AXI_ID_WIDTH_P + AXI_DEST_WIDTH_P + AXI_USER_WIDTH_P;

    router_state_t               r_state;
    logic [SEL_W_C-1:0]          r_lock_dest;

    logic                        w_accept;
    logic                        w_dest_ok;
    logic                        w_load;
    logic                        w_drop_first;
    logic [SEL_W_C-1:0]          w_dest_sel;
    logic [SEL_W_C-1:0]          w_sel;
    logic                        w_out_vld;
    logic                        w_pop;
    logic [PAY_W_C-1:0]          w_in_payload;
    logic [PAY_W_C-1:0]          w_out_payload;

    logic [AXI_DATA_WIDTH_P-1:0] w_tdata;
    logic [AXI_STRB_WIDTH_P-1:0] w_tstrb;
    logic [AXI_KEEP_WIDTH_P-1:0] w_tkeep;
    logic                        w_tlast;
    logic [AXI_ID_WIDTH_P-1:0]   w_tid;
    logic [AXI_DEST_WIDTH_P-1:0] w_tdest;
    logic [AXI_USER_WIDTH_P-1:0] w_tuser;

    // Sinking never stalls; otherwise accept only when the register frees up
    assign o_mst_tready = (r_state == DROP_E) || !w_out_vld || w_pop;
    assign w_accept     = i_mst_tvalid && o_mst_tready;

    // Zero-extended compare so NR_OF_SLAVES_P == 2**AXI_DEST_WIDTH_P works
    assign w_dest_ok    = (32'(i_mst_tdest) < 32'(NR_OF_SLAVES_P));
    assign w_dest_sel   = i_mst_tdest[SEL_W_C-1:0];

    // Mid-packet beats ignore their own tdest and follow the locked output
    assign w_sel        = (r_state == ROUTE_E) ? r_lock_dest : w_dest_sel;
    assign w_load       = w_accept && (((r_state == IDLE_E) && w_dest_ok) || (r_state == ROUTE_E));
    assign w_drop_first = w_accept && (r_state == IDLE_E) && !w_dest_ok;

    assign w_in_payload = {i_mst_tdata, i_mst_tstrb, i_mst_tkeep, i_mst_tlast,
                           i_mst_tid, i_mst_tdest, i_mst_tuser};

    axi4s_router_out_reg #(
        .NR_OF_SLAVES_P  (NR_OF_SLAVES_P),
        .SEL_WIDTH_P     (SEL_W_C),
        .PAYLOAD_WIDTH_P (PAY_W_C)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_sel     (w_sel),
        .i_payload (w_in_payload),
        .i_ready   (i_slv_tready),
        .o_vld     (w_out_vld),
        .o_payload (w_out_payload),
        .o_tvalid  (o_slv_tvalid),
        .o_pop     (w_pop)
    );

    assign {w_tdata, w_tstrb, w_tkeep, w_tlast, w_tid, w_tdest, w_tuser} = w_out_payload;

    // Every output carries the same registered payload; tvalid picks the owner
    for (genvar i = 0; i < NR_OF_SLAVES_P; i++) begin : g_out
        assign o_slv_tdata[i] = w_tdata;
        assign o_slv_tstrb[i] = w_tstrb;
        assign o_slv_tkeep[i] = w_tkeep;
        assign o_slv_tlast[i] = w_tlast;
        assign o_slv_tid[i]   = w_tid;
        assign o_slv_tdest[i] = w_tdest;
        assign o_slv_tuser[i] = w_tuser;
    end

    // Packet framing FSM with destination lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE_E;
            r_lock_dest <= '0;
        end else if (w_accept) begin
            case (r_state)
                IDLE_E: begin
                    if (w_dest_ok) begin
                        r_lock_dest <= w_dest_sel;
                        if (!i_mst_tlast) r_state <= ROUTE_E;
                    end else if (!i_mst_tlast) begin
                        r_state <= DROP_E;
                    end
                end
                ROUTE_E, DROP_E: begin
                    if (i_mst_tlast) r_state <= IDLE_E;
                end
                default: r_state <= IDLE_E;
            endcase
        end
    end

`ifdef AXI4S_ROUTER_DROP_CNT_EN
    logic [DROP_CNT_WIDTH_C-1:0] r_drop_cnt;

    // Saturating count of packets sunk for an out-of-range tdest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop_first && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop_first;
`endif

endmodule : axi4s_s2m_router
`default_nettype wire

// File: tb/tb_axi4s_s2m_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4s_s2m_router
// Purpose  : Directed self-checking bench for axi4s_s2m_router, built with
//            three outputs so tdest=3 exercises the drop path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4s_s2m_router;
    import axi4s_router_pkg::*;

    localparam int NR  = 3;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int KW  = 4;
    localparam int IW  = 2;
    localparam int DEW = 2;
    localparam int UW  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic                      i_mst_tvalid;
    logic                      o_mst_tready;
    logic [DW-1:0]             i_mst_tdata;
    logic [SW-1:0]             i_mst_tstrb;
    logic [KW-1:0]             i_mst_tkeep;
    logic                      i_mst_tlast;
    logic [IW-1:0]             i_mst_tid;
    logic [DEW-1:0]            i_mst_tdest;
    logic [UW-1:0]             i_mst_tuser;
    logic [NR-1:0]             o_slv_tvalid;
    logic [NR-1:0]             i_slv_tready;
    logic [NR-1:0][DW-1:0]     o_slv_tdata;
    logic [NR-1:0][SW-1:0]     o_slv_tstrb;
    logic [NR-1:0][KW-1:0]     o_slv_tkeep;
    logic [NR-1:0]             o_slv_tlast;
    logic [NR-1:0][IW-1:0]     o_slv_tid;
    logic [NR-1:0][DEW-1:0]    o_slv_tdest;
    logic [NR-1:0][UW-1:0]     o_slv_tuser;
`ifdef AXI4S_ROUTER_DROP_CNT_EN
    logic [DROP_CNT_WIDTH_C-1:0] o_drop_cnt;
`endif

    axi4s_s2m_router #(
        .NR_OF_SLAVES_P   (NR),
        .AXI_DATA_WIDTH_P (DW),
        .AXI_STRB_WIDTH_P (SW),
        .AXI_KEEP_WIDTH_P (KW),
        .AXI_ID_WIDTH_P   (IW),
        .AXI_DEST_WIDTH_P (DEW),
        .AXI_USER_WIDTH_P (UW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mst_tvalid (i_mst_tvalid),
        .o_mst_tready (o_mst_tready),
        .i_mst_tdata  (i_mst_tdata),
        .i_mst_tstrb  (i_mst_tstrb),
        .i_mst_tkeep  (i_mst_tkeep),
        .i_mst_tlast  (i_mst_tlast),
        .i_mst_tid    (i_mst_tid),
        .i_mst_tdest  (i_mst_tdest),
        .i_mst_tuser  (i_mst_tuser),
        .o_slv_tvalid (o_slv_tvalid),
        .i_slv_tready (i_slv_tready),
        .o_slv_tdata  (o_slv_tdata),
        .o_slv_tstrb  (o_slv_tstrb),
        .o_slv_tkeep  (o_slv_tkeep),
        .o_slv_tlast  (o_slv_tlast),
        .o_slv_tid    (o_slv_tid),
        .o_slv_tdest  (o_slv_tdest),
        .o_slv_tuser  (o_slv_tuser)
`ifdef AXI4S_ROUTER_DROP_CNT_EN
        ,
        .o_drop_cnt   (o_drop_cnt)
`endif
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    logic g_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample/score outputs and note acceptance at negedge, then
    // return 1 time unit after the following posedge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        for (int p = 0; p < NR; p++) begin
            if (o_slv_tvalid[p] && i_slv_tready[p]) begin
                chk("sb_has_expected_beat", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_port", 32'(p), 32'(e.port));
                    chk("out_data", o_slv_tdata[p], e.data);
                    chk("out_last", 32'(o_slv_tlast[p]), 32'(e.last));
                end
            end
        end
        chk("tvalid_onehot", 32'($countones(o_slv_tvalid) <= 1), 32'd1);
        g_acc = i_mst_tvalid && o_mst_tready;
        @(posedge clk);
        #1;
    endtask

    // Present one beat until accepted; exp_port < 0 means it must be sunk
    task automatic send(input logic [1:0] dest, input logic [31:0] data, input logic last,
                        input int exp_port, output int waits);
        exp_t e;
        i_mst_tdata  = data;
        i_mst_tdest  = dest;
        i_mst_tlast  = last;
        i_mst_tstrb  = '1;
        i_mst_tkeep  = '1;
        i_mst_tid    = dest;
        i_mst_tuser  = last;
        i_mst_tvalid = 1'b1;
        waits = 0;
        g_acc = 1'b0;
        while (!g_acc && waits < 50) begin
            cyc();
            waits++;
        end
        chk("accept_in_time", 32'(g_acc), 32'd1);
        if (g_acc && exp_port >= 0) begin
            e.port = exp_port;
            e.data = data;
            e.last = last;
            sb.push_back(e);
        end
        i_mst_tvalid = 1'b0;
    endtask

    initial begin
        int w;
        logic [31:0] d;
        logic [1:0]  b2b_dest [4];

        rst_n        = 1'b0;
        i_mst_tvalid = 1'b0;
        i_mst_tdata  = '0;
        i_mst_tstrb  = '0;
        i_mst_tkeep  = '0;
        i_mst_tlast  = 1'b0;
        i_mst_tid    = '0;
        i_mst_tdest  = '0;
        i_mst_tuser  = '0;
        i_slv_tready = '1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_tvalid", 32'(o_slv_tvalid), 32'd0);
        chk("rst_tdata0", o_slv_tdata[0], 32'd0);
        chk("rst_tlast", 32'(o_slv_tlast), 32'd0);
        chk("rst_state", 32'(u_dut.r_state), 32'(IDLE_E));
`ifdef AXI4S_ROUTER_DROP_CNT_EN
        chk("rst_drop_cnt", o_drop_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        cyc();

        // Single beat to output 2, visible for exactly one cycle
        send(2'd2, 32'hA5A5_0001, 1'b1, 2, w);
        chk("single_latency_tvalid", 32'(o_slv_tvalid), 32'b100);
        chk("single_tdata2", o_slv_tdata[2], 32'hA5A5_0001);
        cyc();
        chk("single_one_cycle", 32'(o_slv_tvalid), 32'd0);

        // 3-beat packet: first tdest=1, later beats carry tdest=3
        send(2'd1, 32'h1111_0001, 1'b0, 1, w);
        chk("pkt_route_state", 32'(u_dut.r_state), 32'(ROUTE_E));
        send(2'd3, 32'h1111_0002, 1'b0, 1, w);
        chk("pkt_locked_out", 32'(o_slv_tvalid), 32'b010);
        send(2'd3, 32'h1111_0003, 1'b1, 1, w);
        chk("pkt_idle_after_last", 32'(u_dut.r_state), 32'(IDLE_E));
        repeat (2) cyc();
        chk("pkt_drained", 32'(sb.size()), 32'd0);

        // Backpressure on output 0 mid-packet for 5 cycles
        send(2'd0, 32'hB0B0_0001, 1'b0, 0, w);
        send(2'd0, 32'hB0B0_0002, 1'b0, 0, w);
        i_slv_tready = 3'b110;
        i_mst_tdata  = 32'hB0B0_0003;
        i_mst_tlast  = 1'b0;
        i_mst_tvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_no_accept", 32'(g_acc), 32'd0);
            chk("bp_mst_tready", 32'(o_mst_tready), 32'd0);
            chk("bp_payload_stable", o_slv_tdata[0], 32'hB0B0_0002);
            chk("bp_tvalid_held", 32'(o_slv_tvalid), 32'b001);
        end
        i_slv_tready = '1;
        send(2'd0, 32'hB0B0_0003, 1'b0, 0, w);
        chk("bp_release_accept", 32'(w), 32'd1);
        send(2'd0, 32'hB0B0_0004, 1'b1, 0, w);
        repeat (2) cyc();
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // 4-beat packet with out-of-range tdest=3 is sunk
        for (int k = 0; k < 4; k++) begin
            send(2'd3, 32'hDEAD_0000 + 32'(k), (k == 3), -1, w);
            chk("drop_ready", 32'(w), 32'd1);
            chk("drop_no_tvalid", 32'(o_slv_tvalid), 32'd0);
        end
        chk("drop_idle_after_last", 32'(u_dut.r_state), 32'(IDLE_E));
`ifdef AXI4S_ROUTER_DROP_CNT_EN
        chk("drop_cnt_one", o_drop_cnt, 32'd1);
`endif
        cyc();

        // Back-to-back single-beat packets, zero bubbles
        b2b_dest[0] = 2'd0;
        b2b_dest[1] = 2'd2;
        b2b_dest[2] = 2'd1;
        b2b_dest[3] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            send(b2b_dest[k], 32'hC0C0_0000 + 32'(k), 1'b1, int'(b2b_dest[k]), w);
            chk("b2b_one_cycle", 32'(w), 32'd1);
            chk("b2b_tvalid", 32'(o_slv_tvalid), 32'(1 << b2b_dest[k]));
        end
        repeat (2) cyc();
        chk("b2b_drained", 32'(sb.size()), 32'd0);

        // Reset mid-packet: in-flight beat is lost, next beat routes by own tdest
        send(2'd1, 32'hE0E0_0001, 1'b0, 1, w);
        send(2'd0, 32'hE0E0_0002, 1'b0, 1, w);
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(o_slv_tvalid), 32'd0);
        chk("midrst_tdata1", o_slv_tdata[1], 32'd0);
        chk("midrst_state", 32'(u_dut.r_state), 32'(IDLE_E));
        chk("midrst_inflight", 32'(sb.size()), 32'd1);
        sb.delete();
        cyc();
        rst_n = 1'b1;
        d = 32'hF0F0_0001;
        send(2'd2, d, 1'b1, 2, w);
        chk("postrst_tvalid", 32'(o_slv_tvalid), 32'b100);
        chk("postrst_tdata2", o_slv_tdata[2], d);
        repeat (2) cyc();
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_axi4s_s2m_router
`default_nettype wire
